// File: rtl/enemy_mgr_pkg.sv
// -----------------------------------------------------------------------------
// enemy_mgr_pkg
// Shared defaults and spawn FSM state encoding for the enemy layer manager.
// -----------------------------------------------------------------------------
package enemy_mgr_pkg;

  localparam int RGB_W_DEF   = 12;
  localparam int SCORE_W_DEF = 8;
  localparam int RAND_W_DEF  = 16;
  localparam int X_W_DEF     = 10;
  localparam int X_MAX_DEF   = 600;

  typedef enum logic [1:0] {
    SP_IDLE = 2'd0,
    SP_WAIT = 2'd1,
    SP_FIRE = 2'd2
  } spawn_state_e;

endpackage

// File: rtl/enemy_mgr_prio_onehot.sv
// -----------------------------------------------------------------------------
// prio_onehot
// Lowest-set-bit one-hot encoder (bit 0 has highest priority).
// Ports:
//   req_i    - request vector
//   onehot_o - one-hot of the lowest set bit of req_i, zero if none set
// -----------------------------------------------------------------------------
module prio_onehot #(
  parameter int N = 3
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] onehot_o
);

  // Two's-complement trick: x & -x isolates the lowest set bit.
  assign onehot_o = req_i & (~req_i + N'(1));

endmodule

// File: rtl/enemy_mgr.sv
// -----------------------------------------------------------------------------
// enemy_mgr
// Enemy-layer manager for N_CH enemy channels: fixed-priority pixel
// compositing, crash/bomb routing to channels, frame-paced spawn scheduling and
// per-frame saturating score accumulation.
//
// Optional feature macro: ENEMY_MGR_BOMB_EN (bomb fan-out to alive channels;
// when undefined bomb_i is ignored and ch_bomb_o is 0).
//
// Ports:
//   clk_vga, rst            - pixel clock, async active-high reset
//   en_i, v_sync_i, rand_i  - game running, frame sync level, random source
//   ch_alpha_i / ch_rgb_i   - per-channel pixel opacity / colour
//   ch_alive_i              - per-channel occupancy
//   ch_score_i              - per-channel score pulses
//   crash_*_i, bomb_i       - collision and bomb events
//   vga_alpha_o, vga_rgb_o  - composited pixel (1-cycle latency)
//   ch_crash_*_o, ch_bomb_o - per-channel event routing
//   ch_spawn_o, spawn_x_o   - one-hot spawn pulse and its x position
//   add_score_o, kill_cnt_o - previous-frame score, total kills
// -----------------------------------------------------------------------------
module enemy_mgr
  import enemy_mgr_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int RGB_W     = RGB_W_DEF,
  parameter int SCORE_W   = SCORE_W_DEF,
  parameter int RAND_W    = RAND_W_DEF,
  parameter int X_W       = X_W_DEF,
  parameter int X_MAX     = X_MAX_DEF,
  parameter int SPAWN_GAP = 30
) (
  input  logic                    clk_vga,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    v_sync_i,
  input  logic [RAND_W-1:0]       rand_i,
  input  logic [N_CH-1:0]         ch_alpha_i,
  input  logic [N_CH*RGB_W-1:0]   ch_rgb_i,
  input  logic [N_CH-1:0]         ch_alive_i,
  input  logic [N_CH*SCORE_W-1:0] ch_score_i,
  input  logic                    crash_enemy_bullet_i,
  input  logic                    crash_me_enemy_i,
  input  logic                    bomb_i,
  output logic                    vga_alpha_o,
  output logic [RGB_W-1:0]        vga_rgb_o,
  output logic [N_CH-1:0]         ch_crash_bullet_o,
  output logic [N_CH-1:0]         ch_crash_me_o,
  output logic [N_CH-1:0]         ch_bomb_o,
  output logic [N_CH-1:0]         ch_spawn_o,
  output logic [X_W-1:0]          spawn_x_o,
  output logic [SCORE_W-1:0]      add_score_o,
  output logic [15:0]             kill_cnt_o
);

  // One extra bit beyond the channel sum so acc + sum cannot wrap.
  localparam int SUM_W = SCORE_W + $clog2(N_CH) + 1;
  localparam int GAP_W = 8;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SPAWN_GAP);
  localparam logic [X_W-1:0]   XMAX_L  = X_W'(X_MAX);

  // ---------------------------------------------------------------- pixel path
  logic [N_CH-1:0]  win_oh;
  logic [N_CH-1:0]  win_q;
  logic [RGB_W-1:0] win_rgb;
  logic             vga_alpha_q;
  logic [RGB_W-1:0] vga_rgb_q;
  logic [N_CH-1:0]  crash_b_q;
  logic [N_CH-1:0]  crash_m_q;

  prio_onehot #(.N(N_CH)) u_pix_prio (
    .req_i    (ch_alpha_i),
    .onehot_o (win_oh)
  );

  always_comb begin
    win_rgb = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (win_oh[k]) win_rgb = ch_rgb_i[k*RGB_W +: RGB_W];
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      vga_alpha_q <= 1'b0;
      vga_rgb_q   <= '0;
      win_q       <= '0;
      crash_b_q   <= '0;
      crash_m_q   <= '0;
    end else begin
      vga_alpha_q <= en_i & (|ch_alpha_i);
      vga_rgb_q   <= win_rgb;
      win_q       <= en_i ? win_oh : '0;
      // Crash inputs refer to the pixel already on the output, i.e. win_q.
      crash_b_q   <= {N_CH{crash_enemy_bullet_i}} & win_q;
      crash_m_q   <= {N_CH{crash_me_enemy_i}} & win_q;
    end
  end

  // --------------------------------------------------------------------- score
  logic               vs_q;
  logic               frame_edge;
  logic               score_gate;
  logic [SUM_W-1:0]   score_sum;
  logic [SUM_W-1:0]   score_tot;
  logic [SCORE_W-1:0] score_sat;
  logic [15:0]        kill_inc;
  logic [SCORE_W-1:0] acc_q;
  logic [SCORE_W-1:0] add_score_q;
  logic [15:0]        kill_q;

  assign frame_edge = v_sync_i & ~vs_q;

  always_comb begin
    score_gate = en_i & ~crash_me_enemy_i;
    score_sum  = '0;
    kill_inc   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      score_sum = score_sum + SUM_W'(ch_score_i[k*SCORE_W +: SCORE_W]);
      if (|ch_score_i[k*SCORE_W +: SCORE_W]) kill_inc = kill_inc + 16'd1;
    end
    if (!score_gate) begin
      score_sum = '0;
      kill_inc  = '0;
    end
    score_tot = SUM_W'(acc_q) + score_sum;
    score_sat = (|score_tot[SUM_W-1:SCORE_W]) ? '1 : score_tot[SCORE_W-1:0];
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      vs_q        <= 1'b1;  // no spurious edge if v_sync is high out of reset
      acc_q       <= '0;
      add_score_q <= '0;
      kill_q      <= '0;
    end else begin
      vs_q   <= v_sync_i;
      kill_q <= kill_q + kill_inc;
      if (frame_edge) begin
        add_score_q <= score_sat;
        acc_q       <= '0;
      end else begin
        acc_q <= score_sat;  // equals acc_q when gated off
      end
    end
  end

  // --------------------------------------------------------------------- spawn
  spawn_state_e     state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d, gap_inc;
  logic [N_CH-1:0]  free_oh;
  logic [X_W-1:0]   rand_x, spawn_x_red;
  logic [N_CH-1:0]  spawn_q;
  logic [X_W-1:0]   spawn_x_q;

  prio_onehot #(.N(N_CH)) u_free_prio (
    .req_i    (~ch_alive_i),
    .onehot_o (free_oh)
  );

  assign rand_x      = rand_i[X_W-1:0];
  assign spawn_x_red = (rand_x < XMAX_L) ? rand_x : rand_x - XMAX_L;
  assign gap_inc     = (gap_q >= GAP_MAX) ? GAP_MAX : gap_q + GAP_W'(1);

  generate
    if (RAND_W > X_W) begin : g_rand_hi
      logic unused_rand_hi;
      assign unused_rand_hi = ^rand_i[RAND_W-1:X_W];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      SP_IDLE: begin
        gap_d = '0;
        if (en_i) state_d = SP_WAIT;
      end
      SP_WAIT: begin
        if (frame_edge) begin
          gap_d = gap_inc;
          if (gap_inc == GAP_MAX && !(&ch_alive_i)) state_d = SP_FIRE;
        end
      end
      SP_FIRE: begin
        gap_d   = '0;
        state_d = SP_WAIT;
      end
      default: begin
        gap_d   = '0;
        state_d = SP_IDLE;
      end
    endcase
    if (!en_i) begin
      state_d = SP_IDLE;
      gap_d   = '0;
    end
  end

  // Spawn outputs are registered on entry to FIRE so they are valid exactly
  // while the FSM sits in FIRE, using the channel/rand seen at the frame edge.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state_q   <= SP_IDLE;
      gap_q     <= '0;
      spawn_q   <= '0;
      spawn_x_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      spawn_q   <= (state_d == SP_FIRE) ? free_oh : '0;
      spawn_x_q <= (state_d == SP_FIRE) ? spawn_x_red : '0;
    end
  end

  // ---------------------------------------------------------------------- bomb
`ifdef ENEMY_MGR_BOMB_EN
  logic [N_CH-1:0] bomb_q;
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) bomb_q <= '0;
    else     bomb_q <= {N_CH{bomb_i & en_i}} & ch_alive_i;
  end
  assign ch_bomb_o = bomb_q;
`else
  logic unused_bomb;
  assign unused_bomb = bomb_i;
  assign ch_bomb_o   = '0;
`endif

  // ------------------------------------------------------------------- outputs
  assign vga_alpha_o       = vga_alpha_q;
  assign vga_rgb_o         = vga_rgb_q;
  assign ch_crash_bullet_o = crash_b_q;
  assign ch_crash_me_o     = crash_m_q;
  assign ch_spawn_o        = spawn_q;
  assign spawn_x_o         = spawn_x_q;
  assign add_score_o       = add_score_q;
  assign kill_cnt_o        = kill_q;

endmodule

// File: tb/tb_enemy_mgr.sv
module tb_enemy_mgr;

  localparam int NC  = 3;
  localparam int RW  = 12;
  localparam int SW  = 8;
  localparam int GAP = 2;

  logic          clk_vga = 1'b0;
  logic          rst;
  logic          en_i;
  logic          v_sync_i;
  logic [15:0]   rand_i;
  logic [NC-1:0] ch_alpha_i;
  logic [NC*RW-1:0] ch_rgb_i;
  logic [NC-1:0] ch_alive_i;
  logic [NC*SW-1:0] ch_score_i;
  logic          crash_enemy_bullet_i;
  logic          crash_me_enemy_i;
  logic          bomb_i;
  logic          vga_alpha_o;
  logic [RW-1:0] vga_rgb_o;
  logic [NC-1:0] ch_crash_bullet_o;
  logic [NC-1:0] ch_crash_me_o;
  logic [NC-1:0] ch_bomb_o;
  logic [NC-1:0] ch_spawn_o;
  logic [9:0]    spawn_x_o;
  logic [SW-1:0] add_score_o;
  logic [15:0]   kill_cnt_o;

  int checks = 0;
  int errors = 0;

  enemy_mgr #(.N_CH(NC), .SPAWN_GAP(GAP)) dut (
    .clk_vga              (clk_vga),
    .rst                  (rst),
    .en_i                 (en_i),
    .v_sync_i             (v_sync_i),
    .rand_i               (rand_i),
    .ch_alpha_i           (ch_alpha_i),
    .ch_rgb_i             (ch_rgb_i),
    .ch_alive_i           (ch_alive_i),
    .ch_score_i           (ch_score_i),
    .crash_enemy_bullet_i (crash_enemy_bullet_i),
    .crash_me_enemy_i     (crash_me_enemy_i),
    .bomb_i               (bomb_i),
    .vga_alpha_o          (vga_alpha_o),
    .vga_rgb_o            (vga_rgb_o),
    .ch_crash_bullet_o    (ch_crash_bullet_o),
    .ch_crash_me_o        (ch_crash_me_o),
    .ch_bomb_o            (ch_bomb_o),
    .ch_spawn_o           (ch_spawn_o),
    .spawn_x_o            (spawn_x_o),
    .add_score_o          (add_score_o),
    .kill_cnt_o           (kill_cnt_o)
  );

  always #5 clk_vga = ~clk_vga;

  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic clear_inputs();
    en_i = 0; v_sync_i = 0; rand_i = '0; ch_alpha_i = '0; ch_rgb_i = '0;
    ch_alive_i = '1; ch_score_i = '0; crash_enemy_bullet_i = 0;
    crash_me_enemy_i = 0; bomb_i = 0;
  endtask

  // Leaves the design out of reset with one clean clock so the sync delay is low.
  task automatic apply_reset();
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    tick();
  endtask

  function automatic int lowest_set(input logic [NC-1:0] v);
    int idx = -1;
    for (int k = NC - 1; k >= 0; k--) if (v[k]) idx = k;
    return idx;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    en_i = 1; ch_alpha_i = 3'b111; ch_score_i = {8'd9, 8'd9, 8'd9};
    bomb_i = 1; crash_enemy_bullet_i = 1;
    tick(); tick();
    checks++;
    if (vga_alpha_o !== 1'b0 || vga_rgb_o !== '0) begin
      errors++; $display("FAIL reset_pixel: got %b/%h expected 0/000", vga_alpha_o, vga_rgb_o);
    end
    checks++;
    if (ch_crash_bullet_o !== '0 || ch_crash_me_o !== '0 || ch_bomb_o !== '0) begin
      errors++; $display("FAIL reset_routes: got %b %b %b expected 000", ch_crash_bullet_o, ch_crash_me_o, ch_bomb_o);
    end
    checks++;
    if (ch_spawn_o !== '0 || spawn_x_o !== '0 || add_score_o !== '0 || kill_cnt_o !== '0) begin
      errors++; $display("FAIL reset_score_spawn: got %b %0d %0d %0d expected 0", ch_spawn_o, spawn_x_o, add_score_o, kill_cnt_o);
    end
    apply_reset();
    // Directed compositing and bullet routing.
    en_i = 1; ch_alpha_i = 3'b110;
    ch_rgb_i = {12'h0F0, 12'hF00, 12'h00F};
    tick();
    checks++;
    if (vga_alpha_o !== 1'b1 || vga_rgb_o !== 12'hF00) begin
      errors++; $display("FAIL pixel_directed: got %b/%h expected 1/f00", vga_alpha_o, vga_rgb_o);
    end
    crash_enemy_bullet_i = 1;
    tick();
    checks++;
    if (ch_crash_bullet_o !== 3'b010) begin
      errors++; $display("FAIL crash_directed: got %b expected 010", ch_crash_bullet_o);
    end
    crash_enemy_bullet_i = 0;
    tick();
    checks++;
    if (ch_crash_bullet_o !== 3'b000) begin
      errors++; $display("FAIL crash_one_cycle: got %b expected 000", ch_crash_bullet_o);
    end
  endtask

  task automatic test_pixel_random();
    logic [NC-1:0] prev_win;
    int w;
    logic [RW-1:0] exp_rgb;
    logic [NC-1:0] exp_cb, exp_cm;
    logic cur_en;
    logic [NC*RW-1:0] rgb_v;
    ch_alpha_i = '0; en_i = 1; ch_score_i = '0;
    tick();
    prev_win = '0;
    for (int i = 0; i < 60; i++) begin
      cur_en = ($urandom_range(0, 3) != 0);
      en_i = cur_en;
      ch_alpha_i = NC'($urandom);
      ch_rgb_i = (NC*RW)'({$urandom, $urandom});
      crash_enemy_bullet_i = $urandom_range(0, 1);
      crash_me_enemy_i = $urandom_range(0, 1);
      w = lowest_set(ch_alpha_i);
      rgb_v = ch_rgb_i;
      exp_rgb = (w >= 0) ? rgb_v[w*RW +: RW] : '0;
      exp_cb = crash_enemy_bullet_i ? prev_win : '0;
      exp_cm = crash_me_enemy_i ? prev_win : '0;
      tick();
      checks++;
      if (vga_alpha_o !== (cur_en && w >= 0)) begin
        errors++; $display("FAIL pixel_alpha[%0d]: got %b expected %b", i, vga_alpha_o, (cur_en && w >= 0));
      end
      if (cur_en) begin
        checks++;
        if (vga_rgb_o !== exp_rgb) begin
          errors++; $display("FAIL pixel_rgb[%0d]: got %h expected %h", i, vga_rgb_o, exp_rgb);
        end
      end
      checks++;
      if (ch_crash_bullet_o !== exp_cb || ch_crash_me_o !== exp_cm) begin
        errors++; $display("FAIL crash_route[%0d]: got %b/%b expected %b/%b", i, ch_crash_bullet_o, ch_crash_me_o, exp_cb, exp_cm);
      end
      prev_win = (cur_en && w >= 0) ? NC'(1 << w) : '0;
    end
    crash_enemy_bullet_i = 0; crash_me_enemy_i = 0;
  endtask

  task automatic test_score();
    int acc, exp_add, exp_kill, s, kills;
    int sc[3];
    logic vs_prev, edge_now, gate;
    apply_reset();
    acc = 0; exp_add = 0; exp_kill = 0; vs_prev = 0;
    for (int i = 0; i < 260; i++) begin
      // Directed opening: 200 + 100 saturate; a pulse during crash_me is dropped.
      if (i < 5) begin
        en_i = 1; crash_me_enemy_i = (i == 2); v_sync_i = (i == 3);
        sc[0] = (i == 0) ? 200 : 0; sc[1] = (i == 1) ? 100 : 0; sc[2] = (i == 2) ? 50 : 0;
      end else begin
        en_i = ($urandom_range(0, 9) != 0);
        crash_me_enemy_i = ($urandom_range(0, 9) == 0);
        v_sync_i = ((i % 23) < 3);
        for (int k = 0; k < 3; k++)
          sc[k] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 255)) : 0;
      end
      ch_score_i = {8'(sc[2]), 8'(sc[1]), 8'(sc[0])};
      gate = en_i && !crash_me_enemy_i;
      s = gate ? sc[0] + sc[1] + sc[2] : 0;
      kills = gate ? int'(sc[0] != 0) + int'(sc[1] != 0) + int'(sc[2] != 0) : 0;
      edge_now = v_sync_i && !vs_prev;
      vs_prev = v_sync_i;
      if (edge_now) begin
        exp_add = sat(acc + s);
        acc = 0;
      end else begin
        acc = sat(acc + s);
      end
      exp_kill = (exp_kill + kills) % 65536;
      tick();
      if (i == 3) begin
        checks++;
        if (add_score_o !== 8'd255 || kill_cnt_o !== 16'd2) begin
          errors++; $display("FAIL score_sat_directed: got %0d/%0d expected 255/2", add_score_o, kill_cnt_o);
        end
      end
      checks++;
      if (add_score_o !== SW'(exp_add) || kill_cnt_o !== 16'(exp_kill)) begin
        errors++; $display("FAIL score[%0d]: got add=%0d kills=%0d expected add=%0d kills=%0d", i, add_score_o, kill_cnt_o, exp_add, exp_kill);
      end
    end
    ch_score_i = '0; crash_me_enemy_i = 0; v_sync_i = 0;
  endtask

  task automatic test_spawn();
    int gap, fidx;
    logic [NC-1:0] exp_sp;
    int exp_x;
    apply_reset();
    en_i = 1; ch_alive_i = 3'b101;
    tick(); tick(); tick();
    gap = 0;
    for (int f = 0; f < 22; f++) begin
      if (f < 4)       ch_alive_i = 3'b101;
      else if (f < 9)  ch_alive_i = 3'b111;
      else if (f == 9) ch_alive_i = 3'b011;
      else if (f < 18) ch_alive_i = ($urandom_range(0, 2) == 0) ? NC'($urandom) : 3'b111;
      else             ch_alive_i = 3'b000;
      if (f == 18) begin
        // Dropping en clears the frame gap.
        en_i = 0; tick(); en_i = 1; tick(); tick();
        gap = 0;
      end
      rand_i = (f == 1) ? 16'd700 : 16'($urandom);
      gap = (gap + 1 > GAP) ? GAP : gap + 1;
      fidx = lowest_set(~ch_alive_i);
      exp_sp = '0; exp_x = 0;
      if (gap == GAP && fidx >= 0) begin
        exp_sp = NC'(1 << fidx);
        exp_x = int'(rand_i[9:0]) % 600;
        gap = 0;
      end
      v_sync_i = 1;
      tick();
      checks++;
      if (ch_spawn_o !== exp_sp) begin
        errors++; $display("FAIL spawn_pulse[%0d]: got %b expected %b", f, ch_spawn_o, exp_sp);
      end
      if (exp_sp != '0) begin
        checks++;
        if (spawn_x_o !== 10'(exp_x)) begin
          errors++; $display("FAIL spawn_x[%0d]: got %0d expected %0d", f, spawn_x_o, exp_x);
        end
      end
      if (f == 1) begin
        checks++;
        if (ch_spawn_o !== 3'b010 || spawn_x_o !== 10'd100) begin
          errors++; $display("FAIL spawn_directed: got %b/%0d expected 010/100", ch_spawn_o, spawn_x_o);
        end
      end
      if (f == 9) begin
        checks++;
        if (ch_spawn_o !== 3'b100) begin
          errors++; $display("FAIL spawn_after_full: got %b expected 100", ch_spawn_o);
        end
      end
      v_sync_i = 0;
      tick();
      checks++;
      if (ch_spawn_o !== '0) begin
        errors++; $display("FAIL spawn_width[%0d]: got %b expected 000", f, ch_spawn_o);
      end
      tick(); tick();
    end
  endtask

  task automatic test_bomb();
    logic [NC-1:0] exp_b;
    en_i = 1; ch_alive_i = 3'b011; bomb_i = 1;
    tick();
`ifdef ENEMY_MGR_BOMB_EN
    exp_b = 3'b011;
`else
    exp_b = 3'b000;
`endif
    checks++;
    if (ch_bomb_o !== exp_b) begin
      errors++; $display("FAIL bomb_directed: got %b expected %b", ch_bomb_o, exp_b);
    end
    bomb_i = 0;
    tick();
    checks++;
    if (ch_bomb_o !== 3'b000) begin
      errors++; $display("FAIL bomb_pulse_width: got %b expected 000", ch_bomb_o);
    end
    for (int i = 0; i < 20; i++) begin
      en_i = $urandom_range(0, 1);
      bomb_i = $urandom_range(0, 1);
      ch_alive_i = NC'($urandom);
`ifdef ENEMY_MGR_BOMB_EN
      exp_b = (en_i && bomb_i) ? ch_alive_i : '0;
`else
      exp_b = '0;
`endif
      tick();
      checks++;
      if (ch_bomb_o !== exp_b) begin
        errors++; $display("FAIL bomb_rand[%0d]: got %b expected %b", i, ch_bomb_o, exp_b);
      end
    end
    bomb_i = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_pixel_random();
    test_score();
    test_spawn();
    test_bomb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
